// File: rtl/fsm_data_pkg.sv
// rtl/fsm_data_pkg.sv - shared state encoding and default sizes for fsm_data_bank
package fsm_data_pkg;

    typedef enum logic [1:0] {
        RESET_STATE = 2'd0,
        LOAD_STATE  = 2'd1,
        HOLD_STATE  = 2'd2,
        EMIT_STATE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;

endpackage

// File: rtl/fsm_data_bank_if.sv
// rtl/fsm_data_bank_if.sv - load/emit handshake bundle; DO_PAR present with FSM_DATA_BANK_PARITY_EN
interface fsm_data_bank_if
    import fsm_data_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             LOAD;
    logic [WIDTH-1:0] DATA;
    logic             LOAD_READY;
    logic             START;
    logic             NOT;
    logic [WIDTH-1:0] DO;
    logic             DO_VALID;
    logic             DO_READY;
`ifdef FSM_DATA_BANK_PARITY_EN
    logic             DO_PAR;
`endif

    modport master (
        output LOAD, DATA, START, NOT, DO_READY,
        input  LOAD_READY, DO, DO_VALID
`ifdef FSM_DATA_BANK_PARITY_EN
        , input DO_PAR
`endif
    );

    modport slave (
        input  LOAD, DATA, START, NOT, DO_READY,
        output LOAD_READY, DO, DO_VALID
`ifdef FSM_DATA_BANK_PARITY_EN
        , output DO_PAR
`endif
    );

endinterface

// File: rtl/fsm_data_bank_regs.sv
// rtl/fsm_data_bank_regs.sv - CHANNELS x WIDTH word bank with one write port and one read mux
module fsm_data_bank_regs #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int PTR_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_bank [CHANNELS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) r_bank[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (i_we && (i_waddr == PTR_W'(i))) r_bank[i] <= i_wdata;
            end
        end
    end

    // Addresses at or beyond CHANNELS (one past the last word) read as zero.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (i_raddr == PTR_W'(i)) o_rdata = r_bank[i];
        end
    end

endmodule

// File: rtl/fsm_data_bank.sv
// rtl/fsm_data_bank.sv - load words into a bank, emit them in order (optionally inverted); FSM_DATA_BANK_PARITY_EN adds DO_PAR
module fsm_data_bank
    import fsm_data_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   CHANNELS = DEF_CHANNELS,
    localparam int  PTR_W    = $clog2(CHANNELS + 1)
) (
    input  logic             clk,
    input  logic             RESTART_N,
    input  logic             ABORT,
    fsm_data_bank_if.slave   bus,
    output logic [1:0]       p_state,
    output logic [PTR_W-1:0] COUNT
);

    state_t           r_state;
    state_t           w_next;
    logic [PTR_W-1:0] r_count;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             r_inv;
    logic [WIDTH-1:0] r_do;
    logic             r_do_valid;
`ifdef FSM_DATA_BANK_PARITY_EN
    logic             r_do_par;
`endif

    logic             w_load_ready;
    logic             w_wr;
    logic             w_start_acc;
    logic             w_emit_adv;
    logic             w_emit_done;
    logic [PTR_W-1:0] w_rd_next;
    logic [PTR_W-1:0] w_raddr;
    logic [WIDTH-1:0] w_rdata;
    logic [WIDTH-1:0] w_do_next;

    assign w_load_ready = ((r_state == RESET_STATE) || (r_state == LOAD_STATE)) &&
                          (r_count < PTR_W'(CHANNELS));
    assign w_wr         = bus.LOAD && w_load_ready && !ABORT;
    assign w_rd_next    = r_rd_ptr + PTR_W'(1);
    // Word 0 is read at START; during emission the mux looks one word ahead.
    assign w_raddr      = (r_state == EMIT_STATE) ? w_rd_next : '0;
    assign w_do_next    = w_rdata ^ {WIDTH{w_start_acc ? bus.NOT : r_inv}};

    fsm_data_bank_regs #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .PTR_W    (PTR_W)
    ) u_regs (
        .clk     (clk),
        .rst_n   (RESTART_N),
        .i_we    (w_wr),
        .i_waddr (r_count),
        .i_wdata (bus.DATA),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge RESTART_N) begin
        if (!RESTART_N) r_state <= RESET_STATE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_acc = 1'b0;
        w_emit_adv  = 1'b0;
        w_emit_done = 1'b0;
        if (ABORT) begin
            w_next = RESET_STATE;
        end else begin
            case (r_state)
                RESET_STATE: begin
                    if (w_wr) w_next = (CHANNELS == 1) ? HOLD_STATE : LOAD_STATE;
                end
                LOAD_STATE: begin
                    if (bus.START) begin
                        w_next      = EMIT_STATE;
                        w_start_acc = 1'b1;
                    end else if (w_wr && (r_count == PTR_W'(CHANNELS - 1))) begin
                        w_next = HOLD_STATE;
                    end
                end
                HOLD_STATE: begin
                    if (bus.START) begin
                        w_next      = EMIT_STATE;
                        w_start_acc = 1'b1;
                    end
                end
                EMIT_STATE: begin
                    if (r_do_valid && bus.DO_READY) begin
                        if (w_rd_next == r_count) begin
                            w_next      = RESET_STATE;
                            w_emit_done = 1'b1;
                        end else begin
                            w_emit_adv = 1'b1;
                        end
                    end
                end
                default: w_next = RESET_STATE;
            endcase
        end
    end

    // ABORT clears occupancy and valid only; DO and the bank keep their contents.
    always_ff @(posedge clk or negedge RESTART_N) begin
        if (!RESTART_N) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_inv      <= 1'b0;
            r_do       <= '0;
            r_do_valid <= 1'b0;
`ifdef FSM_DATA_BANK_PARITY_EN
            r_do_par   <= 1'b0;
`endif
        end else if (ABORT) begin
            r_count    <= '0;
            r_do_valid <= 1'b0;
        end else begin
            if (w_wr) r_count <= r_count + PTR_W'(1);
            if (w_start_acc) begin
                r_inv      <= bus.NOT;
                r_rd_ptr   <= '0;
                r_do_valid <= 1'b1;
            end
            if (w_emit_adv) r_rd_ptr <= w_rd_next;
            if (w_start_acc || w_emit_adv) begin
                r_do <= w_do_next;
`ifdef FSM_DATA_BANK_PARITY_EN
                r_do_par <= ^w_do_next;
`endif
            end
            if (w_emit_done) begin
                r_do_valid <= 1'b0;
                r_count    <= '0;
            end
        end
    end

    assign bus.LOAD_READY = w_load_ready;
    assign bus.DO         = r_do;
    assign bus.DO_VALID   = r_do_valid;
`ifdef FSM_DATA_BANK_PARITY_EN
    assign bus.DO_PAR     = r_do_par;
`endif
    assign p_state        = r_state;
    assign COUNT          = r_count;

endmodule

// File: doc/fsm_data_bank.md
Name: fsm_data_bank

Overview:
- Parametrised successor to the team's single-word load/invert data FSM.
- Captures up to CHANNELS words of WIDTH bits into an internal register bank through a LOAD/LOAD_READY handshake.
- On START, emits the stored words in order, optionally bit-inverted, through a DO_VALID/DO_READY handshake.
- Sits between a data source and a back-pressured consumer on one clock domain.

Parameters:
- WIDTH, 4: data word width in bits.
- CHANNELS, 4: bank depth in words; must be at least 1.
- PTR_W, $clog2(CHANNELS+1): localparam, not overridable; width of the write and read pointers.

Ports:
- clk  in  1  single clock; all flops are rising-edge triggered.
- RESTART_N  in  1  asynchronous, active-low reset.
- ABORT  in  1  synchronous abort to RESET_STATE.
- LOAD  in  1  source word valid.
- DATA  in  WIDTH  source word.
- LOAD_READY  out  1  bank can accept a word.
- START  in  1  request to emit the stored words.
- NOT  in  1  invert mode, sampled when START is accepted.
- DO  out  WIDTH  output word (registered).
- DO_VALID  out  1  DO is valid.
- DO_READY  in  1  consumer accepts DO.
- p_state  out  2  present FSM state.
- COUNT  out  PTR_W  number of words currently stored.

Behaviour:
- Interface: one clock (clk). Reset is asynchronous and active-low (RESTART_N).
- Reset values: p_state=RESET_STATE, DO=0, DO_VALID=0, COUNT=0, write pointer 0, read pointer 0, inv flag 0. Bank contents are cleared to 0.
- State encoding: RESET_STATE=0, LOAD_STATE=1, HOLD_STATE=2, EMIT_STATE=3.
- LOAD_READY = (p_state is RESET_STATE or LOAD_STATE) and COUNT<CHANNELS. It does not depend on START.
- Write: when LOAD && LOAD_READY, bank[COUNT] <= DATA and COUNT increments.
- RESET_STATE:
  - Any write moves the FSM to LOAD_STATE, or to HOLD_STATE if CHANNELS==1.
  - START is ignored while COUNT==0.
- LOAD_STATE:
  - The write that makes COUNT reach CHANNELS moves the FSM to HOLD_STATE.
  - LOAD=0 keeps the FSM in LOAD_STATE.
  - START moves the FSM to EMIT_STATE.
- HOLD_STATE: bank full; LOAD is ignored. START moves the FSM to EMIT_STATE.
- START acceptance (in LOAD_STATE or HOLD_STATE):
  - inv <= NOT; read pointer <= 0.
  - Next cycle: DO = bank[0] (or ~bank[0] if inv), DO_VALID=1. Latency from START to first word is 1 cycle.
  - If LOAD and START are both high in LOAD_STATE, the write completes and the new word is included in the emission.
- EMIT_STATE:
  - DO and DO_VALID are held stable while DO_READY=0.
  - On DO_VALID && DO_READY, the read pointer increments and DO loads the next word in the same edge.
  - After the handshake of word COUNT-1: DO_VALID=0, DO retains the last emitted value, COUNT=0, FSM returns to RESET_STATE.
  - Bank contents are retained but unreadable until reloaded.
- ABORT (synchronous, highest priority after reset):
  - From any state, the next state is RESET_STATE, COUNT=0, DO_VALID=0.
  - DO and bank contents are unchanged.
- RESTART_N low mid-emit: all outputs go to their reset values immediately, with no clock edge required.
- Illegal or unreachable state encoding: the next state is RESET_STATE.

Optional Feature:
- Macro: FSM_DATA_BANK_PARITY_EN.
- Defined: adds output port DO_PAR (1 bit) = even parity (XOR reduction) of the word loaded into DO. It is registered in the same edge as DO and resets to 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package fsm_data_pkg holds:
  - state constants RESET_STATE, LOAD_STATE, HOLD_STATE, EMIT_STATE;
  - the 2-bit state typedef;
  - the default WIDTH and CHANNELS constants.
- One natural sub-module, fsm_data_bank_regs: the CHANNELS×WIDTH register bank with write port, read mux, and reset clear.
- The FSM, pointers and DO register stay in the top module.

Test Plan:
- Reset, then load 4'h3, 4'h5, 4'hA, 4'hC with LOAD held, then START (NOT=0), DO_READY=1 → DO sequence 3, 5, A, C on 4 consecutive cycles starting 1 cycle after START; COUNT=0 and p_state=0 afterwards.
- Load 2 words 4'h1, 4'h6, then START with NOT=1 → DO=E then 9; LOAD_READY=1 throughout loading; returns to RESET_STATE.
- Full bank, then LOAD with 4'hF in HOLD_STATE → ignored, LOAD_READY=0; emission shows the original 4 words only.
- During EMIT, toggle DO_READY 0/1 every cycle → each word is held until accepted; no word is lost or duplicated.
- Assert ABORT mid-emit after word 1 → next cycle DO_VALID=0, COUNT=0, p_state=0, and DO keeps the last value. Separately, drop RESTART_N mid-emit → DO=0 and DO_VALID=0 asynchronously.
- With FSM_DATA_BANK_PARITY_EN defined, emit 4'h7 and 4'h3 → DO_PAR = 1 then 0.
